// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma -- sprite DMA sequencer running on the CPU clock.
//
// A CPU write to DMA_REG_ADDR latches the source page P and halts the CPU.
// The block then owns the CPU-side bus. It copies XFER_LEN bytes from
// $PP00.. into PPU OAM as alternating READ ($PPxx) and WRITE (OAM_DATA_ADDR)
// cycles. The top level muxes dma_addr_o/dma_rw_o/dma_data_o in place of the
// CPU's outputs while dma_active_o is high.
//
// Optional feature (macro OAM_DMA_ODD_ALIGN_EN):
//   defined   : an ALIGN cycle is inserted after HALT when HALT lands on
//               parity 0, so that every READ falls on a parity-0 (get) cycle.
//   undefined : ALIGN is never entered; a transfer is always 1 + 2*XFER_LEN
//               cycles long.
//
// Ports:
//   clk           in   CPU clock
//   rst           in   synchronous reset, active-low
//   cpu_addr_i    in   CPU address (trigger decode, HALT address)
//   cpu_rw_i      in   CPU read(1)/write(0)
//   cpu_data_i    in   CPU write data (page byte on trigger)
//   bus_data_i    in   read data returned from the shared bus
//   rdy_o         out  CPU ready, 0 = CPU halted
//   dma_active_o  out  1 = bus mux selects DMA outputs
//   dma_addr_o    out  DMA bus address
//   dma_rw_o      out  DMA read(1)/write(0)
//   dma_data_o    out  DMA write data (the read-data latch)
//   busy_o        out  transfer in progress, identical to dma_active_o
// -----------------------------------------------------------------------------
module oam_dma #(
   parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
   // bytes per transfer; power of two, at most 256
   parameter int unsigned XFER_LEN      = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr_i,
   input  logic        cpu_rw_i,
   input  logic [7:0]  cpu_data_i,
   input  logic [7:0]  bus_data_i,
   output logic        rdy_o,
   output logic        dma_active_o,
   output logic [15:0] dma_addr_o,
   output logic        dma_rw_o,
   output logic [7:0]  dma_data_o,
   output logic        busy_o
);

   // index of the final byte; the closing WRITE of this byte ends the transfer
   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_READ  = 3'd3,
      ST_WRITE = 3'd4
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [7:0]  idx_r;
   logic [7:0]  idx_s;
   logic [7:0]  page_r;
   logic [7:0]  page_s;
   logic        parity_r;
   logic        trigger_s;

   logic        rdy_s;
   logic        active_s;
   logic [15:0] addr_s;
   logic        rw_s;
   logic [7:0]  data_s;

   // CPU write to the DMA register; only acted upon in IDLE
   assign trigger_s = (cpu_addr_i == DMA_REG_ADDR) && (cpu_rw_i == 1'b0);

   // busy is the same registered flag as the bus-mux select
   assign busy_o = dma_active_o;

   // State, index, page and get/put parity registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r  <= ST_IDLE;
         idx_r    <= 8'd0;
         page_r   <= 8'd0;
         parity_r <= 1'b0;
      end else begin
         state_r  <= state_s;
         idx_r    <= idx_s;
         page_r   <= page_s;
         parity_r <= ~parity_r;
      end
   end

   // Next-state logic: trigger decode, optional alignment and byte sequencing
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      page_s  = page_r;
      case (state_r)
         ST_IDLE: begin
            if (trigger_s) begin
               state_s = ST_HALT;
               page_s  = cpu_data_i;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
            // parity 0 in HALT would put READ on a put cycle; burn one cycle
            if (parity_r == 1'b0) begin
               state_s = ST_ALIGN;
            end else begin
               state_s = ST_READ;
            end
`else
            state_s = ST_READ;
`endif
         end
         ST_ALIGN: begin
            state_s = ST_READ;
         end
         ST_READ: begin
            state_s = ST_WRITE;
         end
         ST_WRITE: begin
            // the index never carries into the page byte; last byte ends it
            if (idx_r == LAST_IDX) begin
               idx_s   = 8'd0;
               state_s = ST_IDLE;
            end else begin
               idx_s   = idx_r + 8'd1;
               state_s = ST_READ;
            end
         end
         default: begin
            state_s = ST_IDLE;
            idx_s   = 8'd0;
         end
      endcase
   end

   // Output decode from the upcoming state so the outputs register on the
   // same edge the state changes (HALT is visible right after the trigger)
   always_comb begin
      rdy_s    = 1'b1;
      active_s = 1'b0;
      rw_s     = 1'b1;
      addr_s   = dma_addr_o;
      case (state_s)
         ST_IDLE: begin
            rdy_s    = 1'b1;
            active_s = 1'b0;
         end
         ST_HALT: begin
            // HALT is only entered from IDLE, so this is the trigger address
            rdy_s    = 1'b0;
            active_s = 1'b1;
            addr_s   = cpu_addr_i;
         end
         ST_ALIGN: begin
            rdy_s    = 1'b0;
            active_s = 1'b1;
         end
         ST_READ: begin
            rdy_s    = 1'b0;
            active_s = 1'b1;
            addr_s   = {page_s, idx_s};
         end
         ST_WRITE: begin
            rdy_s    = 1'b0;
            active_s = 1'b1;
            rw_s     = 1'b0;
            addr_s   = OAM_DATA_ADDR;
         end
         default: begin
            rdy_s    = 1'b1;
            active_s = 1'b0;
         end
      endcase
   end

   // Data latch: capture the bus at the closing edge of READ, else hold
   always_comb begin
      if (state_r == ST_READ) begin
         data_s = bus_data_i;
      end else begin
         data_s = dma_data_o;
      end
   end

   // Registered bus outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         rdy_o        <= 1'b1;
         dma_active_o <= 1'b0;
         dma_addr_o   <= 16'h0000;
         dma_rw_o     <= 1'b1;
         dma_data_o   <= 8'h00;
      end else begin
         rdy_o        <= rdy_s;
         dma_active_o <= active_s;
         dma_addr_o   <= addr_s;
         dma_rw_o     <= rw_s;
         dma_data_o   <= data_s;
      end
   end

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma -- self-checking bench for oam_dma.
// A simple memory returns addr[7:0]^key. Each transfer is predicted as a full
// bus trace: HALT (plus ALIGN when enabled and HALT parity is 0), then
// 256 READ/WRITE pairs. The recorded DUT trace is compared against it.
// -----------------------------------------------------------------------------
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_addr_i;
   logic        cpu_rw_i;
   logic [7:0]  cpu_data_i;
   logic [7:0]  bus_data_i;
   logic        rdy_o;
   logic        dma_active_o;
   logic [15:0] dma_addr_o;
   logic        dma_rw_o;
   logic [7:0]  dma_data_o;
   logic        busy_o;

`ifdef OAM_DMA_ODD_ALIGN_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   oam_dma dut (
      .clk(clk), .rst(rst),
      .cpu_addr_i(cpu_addr_i), .cpu_rw_i(cpu_rw_i), .cpu_data_i(cpu_data_i),
      .bus_data_i(bus_data_i),
      .rdy_o(rdy_o), .dma_active_o(dma_active_o), .dma_addr_o(dma_addr_o),
      .dma_rw_o(dma_rw_o), .dma_data_o(dma_data_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   // memory model
   logic [7:0] key = 8'h00;
   assign bus_data_i = dma_addr_o[7:0] ^ key;

   // get/put parity as seen during the cycle after each edge
   logic par_m = 1'b0;
   always @(posedge clk) par_m <= rst ? ~par_m : 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   // recorded bus trace of the last transfer
   logic [15:0] tr_addr[$];
   logic        tr_rw[$];
   logic [7:0]  tr_dat[$];
   int          last_len;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic idle_inputs();
      cpu_addr_i = 16'h8000 | 16'($urandom_range(0, 32767));
      cpu_rw_i   = 1'($urandom_range(0, 1));
      cpu_data_i = 8'($urandom_range(0, 255));
   endtask

   // Called just after a negedge with the DUT idle: triggers a transfer of
   // page, optionally pokes the DMA register after write poke_at, optionally
   // resets after write rst_at. Returns at the first negedge back in IDLE.
   task automatic run_xfer(input logic [7:0] page, input int poke_at,
                           input int rst_at, input string tag);
      logic [15:0] ea[$];
      logic        erw[$];
      logic [7:0]  ed[$];
      bit          align, aborted, poked;
      int          n, wr, bad, cons_bad;
      tr_addr.delete(); tr_rw.delete(); tr_dat.delete();
      chk({tag, "_idle_before"}, rdy_o, 1);
      cpu_addr_i = 16'h4014; cpu_rw_i = 1'b0; cpu_data_i = page;
      @(negedge clk);
      align = ALIGN_EN && (par_m == 1'b0);
      chk({tag, "_rdy_fall"}, rdy_o, 0);
      // expected trace
      for (int i = 0; i < (align ? 2 : 1); i++) begin
         ea.push_back(16'h4014); erw.push_back(1'b1); ed.push_back(8'h00);
      end
      for (int k = 0; k < 256; k++) begin
         ea.push_back({page, 8'(k)}); erw.push_back(1'b1); ed.push_back(8'h00);
         ea.push_back(16'h2004); erw.push_back(1'b0); ed.push_back(8'(k) ^ key);
      end
      n = 0; wr = 0; aborted = 1'b0; poked = 1'b0; cons_bad = 0;
      while (rdy_o == 1'b0 && n < 600 && !aborted) begin
         if (dma_active_o !== 1'b1 || busy_o !== 1'b1) cons_bad++;
         tr_addr.push_back(dma_addr_o); tr_rw.push_back(dma_rw_o);
         tr_dat.push_back(dma_data_o);
         if (!dma_rw_o) wr++;
         idle_inputs();
         if (!dma_rw_o && wr == poke_at && !poked) begin
            cpu_addr_i = 16'h4014; cpu_rw_i = 1'b0; cpu_data_i = 8'h03;
            poked = 1'b1;
         end
         if (!dma_rw_o && wr == rst_at) begin
            rst = 1'b0;
            @(negedge clk);
            chk({tag, "_rst_rdy"}, rdy_o, 1);
            chk({tag, "_rst_active"}, dma_active_o, 0);
            chk({tag, "_rst_busy"}, busy_o, 0);
            chk({tag, "_rst_addr"}, dma_addr_o, 0);
            chk({tag, "_rst_rw"}, dma_rw_o, 1);
            chk({tag, "_rst_data"}, dma_data_o, 0);
            rst = 1'b1;
            aborted = 1'b1;
         end else begin
            @(negedge clk);
            n++;
         end
      end
      bad = -1;
      for (int i = 0; i < tr_addr.size(); i++) begin
         if (i >= ea.size() || tr_addr[i] !== ea[i] || tr_rw[i] !== erw[i] ||
             (!erw[i] && tr_dat[i] !== ed[i])) begin
            bad = i;
            break;
         end
      end
      chk({tag, "_trace_first_bad_idx"}, bad, -1);
      chk({tag, "_active_busy_consistent"}, cons_bad, 0);
      last_len = n;
      if (!aborted) begin
         chk({tag, "_len"}, n, align ? 514 : 513);
         chk({tag, "_trace_size"}, tr_addr.size(), ea.size());
         chk({tag, "_active_drop"}, dma_active_o, 0);
         chk({tag, "_data_hold"}, dma_data_o, 8'hFF ^ key);
      end
   endtask

   // wait in IDLE until the next trigger would give HALT parity == target
   task automatic align_to(input bit target);
      int guard = 0;
      while (~par_m != target && guard < 4) begin
         idle_inputs();
         @(negedge clk);
         guard++;
      end
   endtask

   typedef struct {
      logic [7:0] page;
      logic [7:0] key;
      bit         halt_par;
      int         exp_len;
   } vec_t;

   initial begin
      vec_t tbl[5];
      int   first_w, second_w;
      logic [15:0] last_r;
      int   off_page;

      tbl[0] = '{8'h02, 8'h5A, 1'b0, 0};
      tbl[1] = '{8'h07, 8'hA5, 1'b1, 0};
      tbl[2] = '{8'h07, 8'hA5, 1'b0, 0};
      tbl[3] = '{8'hFF, 8'h3C, 1'b1, 0};
      tbl[4] = '{8'h00, 8'hC3, 1'b0, 0};
      for (int i = 0; i < 5; i++)
         tbl[i].exp_len = (ALIGN_EN && tbl[i].halt_par == 1'b0) ? 514 : 513;

      // reset state
      rst = 1'b0;
      idle_inputs();
      repeat (3) @(negedge clk);
      chk("reset_rdy", rdy_o, 1);
      chk("reset_active", dma_active_o, 0);
      chk("reset_busy", busy_o, 0);
      chk("reset_addr", dma_addr_o, 0);
      chk("reset_rw", dma_rw_o, 1);
      chk("reset_data", dma_data_o, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // table-driven transfers with controlled HALT parity
      for (int i = 0; i < 5; i++) begin
         key = tbl[i].key;
         align_to(tbl[i].halt_par);
         run_xfer(tbl[i].page, -1, -1, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d_table_len", i), last_len, tbl[i].exp_len);
         if (tbl[i].page == 8'h07) begin
            first_w = -1; second_w = -1; last_r = 16'h0000; off_page = 0;
            for (int j = 0; j < tr_addr.size(); j++) begin
               if (!tr_rw[j]) begin
                  if (first_w < 0) first_w = int'(tr_dat[j]);
                  else if (second_w < 0) second_w = int'(tr_dat[j]);
               end else if (tr_addr[j] != 16'h4014) begin
                  last_r = tr_addr[j];
                  if (tr_addr[j][15:8] != 8'h07) off_page++;
               end
            end
            chk($sformatf("tbl%0d_first_write", i), first_w, 8'hA5);
            chk($sformatf("tbl%0d_second_write", i), second_w, 8'hA4);
            chk($sformatf("tbl%0d_last_read_addr", i), last_r, 16'h07FF);
            chk($sformatf("tbl%0d_reads_off_page", i), off_page, 0);
         end
         repeat (2) begin idle_inputs(); @(negedge clk); end
      end

      // second DMA register write at byte 100 is ignored
      key = 8'h17;
      run_xfer(8'h07, 100, -1, "poke");
      repeat (3) begin idle_inputs(); @(negedge clk); end

      // reset at byte 40, then restart from page $05
      key = 8'h69;
      run_xfer(8'h07, -1, 40, "rst40");
      run_xfer(8'h05, -1, -1, "restart05");
      repeat (2) begin idle_inputs(); @(negedge clk); end

      // back-to-back: trigger on the first IDLE cycle
      key = 8'h81;
      run_xfer(8'h11, -1, -1, "chain_a");
      run_xfer(8'h12, -1, -1, "chain_b");

      // randomized transfers against the model
      for (int r = 0; r < 4; r++) begin
         key = 8'($urandom_range(0, 255));
         repeat ($urandom_range(0, 3)) begin idle_inputs(); @(negedge clk); end
         run_xfer(8'($urandom_range(0, 255)), -1, -1, $sformatf("rand%0d", r));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite DMA sequencer on the CPU clock. A CPU write to the DMA register (page byte P) halts the CPU.
- It then copies 256 bytes from CPU address space $PP00-$PPFF into the PPU OAM by issuing OAMDATA ($2004) writes.
- It owns the CPU-side bus while active. The top level muxes its address/rw/data outputs in place of the CPU's, and the existing chip-select/phase logic applies unchanged.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, address driven on each write cycle.
- XFER_LEN, 256, bytes per transfer; must be a power of two, at most 256.

Ports:
- clk  in  1  CPU clock (clk_cpu)
- rst  in  1  synchronous reset, active-low
- cpu_addr_i  in  16  CPU address
- cpu_rw_i  in  1  CPU read(1)/write(0)
- cpu_data_i  in  8  CPU write data
- bus_data_i  in  8  read data returned from the shared bus
- rdy_o  out  1  CPU ready; 0 = CPU halted
- dma_active_o  out  1  1 = bus mux selects DMA outputs
- dma_addr_o  out  16  DMA bus address
- dma_rw_o  out  1  DMA read(1)/write(0)
- dma_data_o  out  8  DMA write data
- busy_o  out  1  transfer in progress; same as dma_active_o

Behaviour:
- Reset (rst=0 at a clk edge) takes effect on that edge, including mid-transfer:
  - state=IDLE, rdy_o=1, dma_active_o=0, busy_o=0
  - dma_addr_o=0, dma_rw_o=1, dma_data_o=0
  - byte index=0, page=0, parity=0
- Parity bit toggles every clk while out of reset. It is 0 on the first cycle after reset.
- Trigger: in IDLE, cpu_addr_i==DMA_REG_ADDR and cpu_rw_i==0 at an edge → latch page=cpu_data_i, go to HALT. The trigger cycle itself is the CPU's write and completes normally.
- Writes to DMA_REG_ADDR while not IDLE are ignored. The page is not relatched and no restart occurs.
- States and transitions:
  - IDLE: as above.
  - HALT (1 cycle): rdy_o=0, dma_active_o=1, dma_rw_o=1, dma_addr_o=cpu_addr_i held from the trigger. Next state is ALIGN when alignment applies (see Optional Feature), else READ.
  - ALIGN (1 cycle): same outputs as HALT. Next state is READ.
  - READ (1 cycle): dma_addr_o={page, idx}, dma_rw_o=1. bus_data_i is captured into the data latch at the closing edge. Next state is WRITE.
  - WRITE (1 cycle): dma_addr_o=OAM_DATA_ADDR, dma_rw_o=0, dma_data_o=latch. Closing edge:
    - if idx==XFER_LEN-1: idx→0, go to IDLE
    - else idx+1, go to READ
- idx width is 8 bits. Wrap from 255 to 0 terminates the transfer and never crosses into page P+1.
- rdy_o=0 and dma_active_o=1 hold in every state except IDLE. Both return to 1/0 on the cycle after the last WRITE.
- Active length: 1 + align + 2*XFER_LEN cycles, i.e. 513 or 514 for 256 bytes.
- Outputs are registered and change only on clk edges. dma_data_o holds its last value in IDLE.
- A trigger on the cycle immediately after DMA returns to IDLE is accepted normally.
- There is no latency between the trigger edge and HALT: HALT outputs are visible after the trigger edge.

Optional Feature:
- Macro: OAM_DMA_ODD_ALIGN_EN.
- Defined: in HALT, if parity==0 the next state is ALIGN, so every READ falls on parity 0 (get cycle) as on hardware. Total is 514 cycles if HALT is on parity 0, else 513.
- Undefined: ALIGN is never entered and the total is always 513 cycles.

Test Plan:
- Reset, then write $4014=$02 → rdy_o falls the next cycle. 256 WRITE cycles follow, where WRITE k drives addr $2004 with data equal to the byte read from $0200+k. rdy_o returns to 1 exactly 513/514 cycles after the trigger edge.
- With OAM_DMA_ODD_ALIGN_EN: trigger so that HALT parity=0 → 514 active cycles and one ALIGN. Trigger so that HALT parity=1 → 513 cycles. Without the macro, both cases give 513.
- Pattern memory byte=addr[7:0]^$A5 for page $07 → OAM write sequence equals $A5,$A4,…. The last WRITE uses read address $07FF and DMA never reads $0800.
- Second write to $4014=$03 during transfer at byte 100 → ignored. Source addresses stay on page $07 and the total length is unchanged.
- Assert rst=0 at byte 40 → next edge gives rdy_o=1 and dma_active_o=0. A new trigger with $05 restarts at idx 0 from $0500.
- Trigger on the first cycle back in IDLE → second transfer runs with no gap, and rdy_o is high for exactly the one IDLE cycle between them.
